// File: rtl/fifo_rd_adapter.sv
// Two-entry read adapter: pops a show-ahead FIFO and presents words on a registered valid/ready port.
// Optional beat counter on beat_cnt_o when FIFO_RD_ADAPTER_BEAT_CNT_EN is defined.
module fifo_rd_adapter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_o,
    input  logic                  flush_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic [1:0]            level_o
`ifdef FIFO_RD_ADAPTER_BEAT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  beat_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  pop_c;
    logic                  xfer_c;

    // Pop depends only on FIFO status, state and flush, never on m_ready_i.
    assign pop_c     = rst_n & ~fifo_empty_i & (state != FULL) & ~flush_i;
    assign fifo_rd_o = pop_c;
    assign xfer_c    = m_valid_o & m_ready_i;
    assign m_data_o  = out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_q     <= '0;
            skid_q    <= '0;
            m_valid_o <= 1'b0;
            level_o   <= 2'd0;
        end else if (flush_i) begin
            state     <= IDLE;
            m_valid_o <= 1'b0;
            level_o   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        out_q     <= fifo_data_i;
                        state     <= BUSY;
                        m_valid_o <= 1'b1;
                        level_o   <= 2'd1;
                    end
                end
                BUSY: begin
                    if (pop_c && m_ready_i) begin
                        out_q <= fifo_data_i;
                    end else if (pop_c) begin
                        skid_q  <= fifo_data_i;
                        state   <= FULL;
                        level_o <= 2'd2;
                    end else if (m_ready_i) begin
                        state     <= IDLE;
                        m_valid_o <= 1'b0;
                        level_o   <= 2'd0;
                    end
                end
                FULL: begin
                    if (m_ready_i) begin
                        out_q   <= skid_q;
                        state   <= BUSY;
                        level_o <= 2'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    m_valid_o <= 1'b0;
                    level_o   <= 2'd0;
                end
            endcase
        end
    end

`ifdef FIFO_RD_ADAPTER_BEAT_CNT_EN
    // Counts every downstream handshake, including one that coincides with flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_o <= '0;
        end else if (xfer_c) begin
            beat_cnt_o <= beat_cnt_o + CNT_WIDTH'(1);
        end
    end
`else
    logic unused_c;
    assign unused_c = xfer_c;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Self-checking bench for fifo_rd_adapter: a queue-based holding model compared every cycle.
module tb_fifo_rd_adapter;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned NWORDS = 1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_empty_i;
    logic          fifo_rd_o;
    logic          flush_i;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic          m_ready_i;
    logic [1:0]    level_o;
`ifdef FIFO_RD_ADAPTER_BEAT_CNT_EN
    logic [CW-1:0] beat_cnt_o;
    logic [CW-1:0] cnt_mdl;
`endif

    fifo_rd_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_o    (fifo_rd_o),
        .flush_i      (flush_i),
        .m_valid_o    (m_valid_o),
        .m_data_o     (m_data_o),
        .m_ready_i    (m_ready_i),
        .level_o      (level_o)
`ifdef FIFO_RD_ADAPTER_BEAT_CNT_EN
        ,
        .beat_cnt_o   (beat_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src[$];   // upstream FIFO contents
    logic [DW-1:0] mdl[$];   // words held by the adapter, head = on m_data_o
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            stream_on = 1'b0;
    int            rx_next  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive FIFO, check at negedge, advance the model at posedge.
    task automatic tick();
        bit exp_pop;
        bit xfer;
        fifo_empty_i = (src.size() == 0);
        fifo_data_i  = (src.size() == 0) ? '0 : src[0];
        @(negedge clk);
        exp_pop = rst_n && (src.size() > 0) && (mdl.size() < 2) && !flush_i;
        xfer    = rst_n && (mdl.size() > 0) && m_ready_i;
        chk("fifo_rd", 32'(fifo_rd_o), 32'(exp_pop));
        chk("m_valid", 32'(m_valid_o), 32'(mdl.size() > 0));
        chk("level", 32'(level_o), 32'(mdl.size()));
        if (mdl.size() > 0) chk("m_data", 32'(m_data_o), 32'(mdl[0]));
`ifdef FIFO_RD_ADAPTER_BEAT_CNT_EN
        chk("beat_cnt", 32'(beat_cnt_o), 32'(cnt_mdl));
`endif
        if (stream_on && m_valid_o && m_ready_i) begin
            chk("stream", 32'(m_data_o), 32'(rx_next));
            rx_next++;
        end
        @(posedge clk);
        if (!rst_n) begin
            mdl.delete();
`ifdef FIFO_RD_ADAPTER_BEAT_CNT_EN
            cnt_mdl = '0;
`endif
        end else begin
            if (xfer) begin
                void'(mdl.pop_front());
`ifdef FIFO_RD_ADAPTER_BEAT_CNT_EN
                cnt_mdl = cnt_mdl + CW'(1);
`endif
            end
            if (flush_i) mdl.delete();
            else if (exp_pop) mdl.push_back(src[0]);
        end
        if (exp_pop) void'(src.pop_front());
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; m_ready_i = 1'b0;
        fifo_empty_i = 1'b1; fifo_data_i = '0;
`ifdef FIFO_RD_ADAPTER_BEAT_CNT_EN
        cnt_mdl = '0;
`endif
        @(posedge clk); #1;

        // Reset held with a non-empty FIFO: nothing popped, outputs quiet.
        src = '{16'h00A0};
        repeat (2) tick();
        chk("rst_data", 32'(m_data_o), 32'h0);
        chk("rst_src_kept", 32'(src.size()), 32'd1);
        rst_n = 1'b1;
        src.delete();
        tick();

        // Streaming with ready high: one beat per cycle, one cycle latency.
        src = '{16'h00A1, 16'h00A2, 16'h00A3};
        m_ready_i = 1'b1;
        repeat (5) tick();

        // Backpressure fills both entries, then drains in order.
        src = '{16'h0011, 16'h0022, 16'h0033};
        m_ready_i = 1'b0;
        repeat (4) tick();
        chk("full_level", 32'(level_o), 32'd2);
        chk("full_hold", 32'(m_data_o), 32'h0011);
        m_ready_i = 1'b1;
        repeat (5) tick();

        // Flush while BUSY and stalled.
        src = '{16'h0055};
        m_ready_i = 1'b0;
        tick();
        src.push_back(16'h0066);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        src.delete();
        tick();
        chk("flush_valid", 32'(m_valid_o), 32'd0);

        // Reset while FULL discards held words without popping.
        src = '{16'h0001, 16'h0002, 16'h0003};
        repeat (3) tick();
        chk("pre_rst_level", 32'(level_o), 32'd2);
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_full_data", 32'(m_data_o), 32'h0);
        chk("rst_full_src", 32'(src.size()), 32'd1);
        rst_n = 1'b1;
        src.delete();
        tick();

`ifdef FIFO_RD_ADAPTER_BEAT_CNT_EN
        // 17 beats wrap a 4-bit counter to 1; a flush afterwards leaves it alone.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 17; i++) src.push_back(DW'(16'h0100 + i));
        m_ready_i = 1'b1;
        repeat (20) tick();
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        tick();
        chk("beat_wrap", 32'(beat_cnt_o), 32'd1);
`endif

        // Random backpressure and FIFO availability over a counting stream.
        rst_n = 1'b0; m_ready_i = 1'b0; src.delete(); tick(); rst_n = 1'b1;
        stream_on = 1'b1;
        begin
            int pushed = 0;
            for (int c = 0; c < 20000 && rx_next < int'(NWORDS); c++) begin
                if (pushed < int'(NWORDS) && $urandom_range(0, 3) != 0) begin
                    src.push_back(DW'(pushed));
                    pushed++;
                end
                m_ready_i = 1'($urandom_range(0, 1));
                tick();
            end
        end
        chk("stream_done", 32'(rx_next), 32'(NWORDS));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_adapter.md
FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the FIFO data word and the downstream data.
REQ-002 Parameter CNT_WIDTH, default 16, width of beat_cnt_o; used only when FIFO_RD_ADAPTER_BEAT_CNT_EN is defined.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 fifo_data_i  input  DATA_WIDTH  head-of-FIFO word, combinationally valid whenever fifo_empty_i=0.
REQ-006 fifo_empty_i  input  1  FIFO empty flag.
REQ-007 fifo_rd_o  output  1  pop strobe to the FIFO read-valid input; one word is consumed per cycle it is high.
REQ-008 flush_i  input  1  synchronous discard of all held words.
REQ-009 m_valid_o  output  1  downstream data valid.
REQ-010 m_data_o  output  DATA_WIDTH  downstream data, driven from a register.
REQ-011 m_ready_i  input  1  downstream ready; a beat transfers when m_valid_o=1 and m_ready_i=1 in the same cycle.
REQ-012 level_o  output  2  number of words held (0, 1 or 2).
REQ-013 beat_cnt_o  output  CNT_WIDTH  transferred-beat count (present only with FIFO_RD_ADAPTER_BEAT_CNT_EN).

Function
REQ-014 The block SHALL hold up to two words: an output register (out) and a skid register (skid), tracked by state IDLE (0 words), BUSY (out valid), FULL (out and skid valid).
REQ-015 fifo_rd_o SHALL equal (!fifo_empty_i & state!=FULL & !flush_i) and SHALL have no combinational dependence on m_ready_i.
REQ-016 m_valid_o SHALL be 1 in BUSY and FULL and 0 in IDLE; m_data_o SHALL always be out; level_o SHALL be 0/1/2 for IDLE/BUSY/FULL.
REQ-017 IDLE: pop -> out<=fifo_data_i, go BUSY; no pop -> stay IDLE.
REQ-018 BUSY: pop & m_ready_i -> out<=fifo_data_i, stay BUSY; pop & !m_ready_i -> skid<=fifo_data_i, go FULL; !pop & m_ready_i -> go IDLE; !pop & !m_ready_i -> stay BUSY.
REQ-019 FULL: m_ready_i -> out<=skid, go BUSY; !m_ready_i -> stay FULL.
REQ-020 Latency: a word at the FIFO head with the block IDLE SHALL appear on m_data_o with m_valid_o=1 on the cycle after fifo_rd_o is asserted.
REQ-021 Throughput: with fifo_empty_i=0 and m_ready_i=1 continuously, one beat SHALL transfer per cycle.
REQ-022 While m_valid_o=1 and m_ready_i=0, m_data_o SHALL remain stable and m_valid_o SHALL not deassert.
REQ-023 Word order SHALL be preserved: words exit m_data_o in the order popped.
REQ-024 flush_i=1 SHALL force the next state to IDLE regardless of m_ready_i and pop conditions, with fifo_rd_o=0 that cycle; a handshake coinciding with flush counts as transferred.
REQ-025 Simultaneous fifo_empty_i going to 0 and state FULL SHALL produce no pop until the state leaves FULL.

Reset
REQ-026 While rst_n=0 at a clock edge: state<=IDLE, out<=0, skid<=0, beat_cnt_o<=0.
REQ-027 During and after reset: m_valid_o=0, level_o=0, m_data_o=0; fifo_rd_o SHALL be 0 while rst_n=0.
REQ-028 Reset mid-transfer SHALL discard held words without popping the FIFO.

Configuration
REQ-029 With FIFO_RD_ADAPTER_BEAT_CNT_EN defined, beat_cnt_o SHALL increment by 1 on every downstream handshake, wrap from 2^CNT_WIDTH-1 to 0, be unaffected by flush_i, and clear only on reset.
REQ-030 Without FIFO_RD_ADAPTER_BEAT_CNT_EN, port beat_cnt_o and its counter SHALL not exist; all other behaviour is identical.

Verification
REQ-031 FIFO holds 0xA1,0xA2,0xA3, m_ready_i=1 -> fifo_rd_o high 3 cycles, m_data_o 0xA1,0xA2,0xA3 on consecutive cycles starting 1 cycle after first pop.
REQ-032 FIFO holds 0x11,0x22,0x33, m_ready_i=0 -> two pops, level_o=2, fifo_rd_o=0, m_data_o=0x11 held; then m_ready_i=1 -> output 0x11,0x22,0x33 in order.
REQ-033 BUSY with 0x55, flush_i=1 for one cycle, m_ready_i=0 -> next cycle m_valid_o=0, level_o=0, no pop during flush cycle.
REQ-034 rst_n=0 asserted while FULL -> next cycle m_valid_o=0, m_data_o=0, level_o=0, fifo_rd_o=0 while reset held.
REQ-035 Random m_ready_i (50%) over 1000 words from a counting FIFO -> output sequence 0,1,2,... with no loss/duplication; fifo_rd_o never high when fifo_empty_i=1 or state FULL.
REQ-036 With FIFO_RD_ADAPTER_BEAT_CNT_EN, CNT_WIDTH=4, 17 transferred beats -> beat_cnt_o=1 (wrap); flush mid-run leaves count unchanged.
